// File: rtl/go_pkg.sv
// Shared types and constants for the Go board controller: cell encodings,
// command opcodes, FSM states and the 0..8 wrapping step used by the cursor.
package go_pkg;

    localparam int unsigned BOARD_N     = 9;
    localparam logic [7:0]  CURSOR_HOME = 8'h44;

    typedef enum logic [1:0] {
        CELL_EMPTY = 2'b00,
        CELL_BLACK = 2'b01,
        CELL_WHITE = 2'b10,
        CELL_RED   = 2'b11
    } cell_t;

    typedef enum logic [2:0] {
        CMD_NOP   = 3'd0,
        CMD_UP    = 3'd1,
        CMD_DOWN  = 3'd2,
        CMD_LEFT  = 3'd3,
        CMD_RIGHT = 3'd4,
        CMD_PLACE = 3'd5,
        CMD_PASS  = 3'd6,
        CMD_CLEAR = 3'd7
    } cmd_t;

    typedef enum logic [1:0] {
        ST_PLAY        = 2'd0,
        ST_CLEAR_SWEEP = 2'd1,
        ST_OVER        = 2'd2
    } state_t;

    // Step a 0..BOARD_N-1 coordinate by one with wrap-around; inc=1 counts up.
    function automatic logic [3:0] wrap_step(input logic [3:0] val, input logic inc);
        logic [3:0] res;
        if (inc) begin
            res = (val == 4'(BOARD_N - 1)) ? 4'd0 : val + 4'd1;
        end else begin
            res = (val == 4'd0) ? 4'(BOARD_N - 1) : val - 4'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/go_cursor.sv
// Working cursor register: applies UP/DOWN/LEFT/RIGHT moves with wrap and
// reloads the home position at the end of a board clear.
module go_cursor
    import go_pkg::*;
#(
    parameter logic [7:0] HOME = 8'h44
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       move_en_i,
    input  logic [2:0] move_cmd_i,
    input  logic       home_i,
    output logic [7:0] cursor_o,
    output logic [3:0] row_o,
    output logic [3:0] col_o
);

    logic [3:0] row_q, row_d;
    logic [3:0] col_q, col_d;

    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (home_i) begin
            row_d = HOME[7:4];
            col_d = HOME[3:0];
        end else if (move_en_i) begin
            case (cmd_t'(move_cmd_i))
                CMD_UP:    row_d = wrap_step(row_q, 1'b0);
                CMD_DOWN:  row_d = wrap_step(row_q, 1'b1);
                CMD_LEFT:  col_d = wrap_step(col_q, 1'b0);
                CMD_RIGHT: col_d = wrap_step(col_q, 1'b1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            row_q <= HOME[7:4];
            col_q <= HOME[3:0];
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    assign cursor_o = {row_q, col_q};
    assign row_o    = row_q;
    assign col_o    = col_q;

endmodule

// File: rtl/go_board_ctrl.sv
// Go game-state producer: accepts move commands, keeps the working board,
// turn and counters, and commits frame-synchronous shadow copies for display.
module go_board_ctrl
    import go_pkg::*;
#(
    parameter int unsigned BOARD_N     = go_pkg::BOARD_N,
    parameter logic [7:0]  CURSOR_HOME = go_pkg::CURSOR_HOME
) (
    input  logic                                 clk,
    input  logic                                 reset_n,
    input  logic                                 frame_start,
    input  logic                                 cmd_valid,
    input  logic [2:0]                           cmd,
    output logic                                 cmd_ready,
    output logic [BOARD_N-1:0][BOARD_N-1:0][1:0] board,
    output logic [7:0]                           cursor_pos,
    output logic                                 turn,
    output logic [6:0]                           move_count,
    output logic                                 place_err,
    output logic                                 game_over
);

    state_t                               state_q;
    logic [BOARD_N-1:0][BOARD_N-1:0][1:0] work_board_q;
    logic [BOARD_N-1:0][BOARD_N-1:0][1:0] board_q;
    logic [7:0]                           cursor_pos_q;
    logic                                 turn_q;
    logic [6:0]                           move_count_q;
    logic [1:0]                           pass_cnt_q;
    logic                                 place_err_q;
    logic                                 game_over_q;
    logic                                 cmd_ready_q;
    logic [3:0]                           sweep_row_q;
    logic [3:0]                           sweep_col_q;

    logic [7:0] work_cursor;
    logic [3:0] cur_row;
    logic [3:0] cur_col;
    cmd_t       cmd_op;
    logic       cmd_acc;
    logic       move_en;
    logic       sweep_done;
    logic       cell_free;

    assign cmd_op     = cmd_t'(cmd);
    assign cmd_acc    = cmd_valid & cmd_ready_q;
    assign move_en    = cmd_acc & (state_q == ST_PLAY);
    // Sweep has written (8,8) once the row counter steps past the last row.
    assign sweep_done = (state_q == ST_CLEAR_SWEEP) && (sweep_row_q == 4'(BOARD_N));
    assign cell_free  = (work_board_q[cur_row][cur_col] == CELL_EMPTY);

    go_cursor #(
        .HOME (CURSOR_HOME)
    ) u_cursor (
        .clk        (clk),
        .reset_n    (reset_n),
        .move_en_i  (move_en),
        .move_cmd_i (cmd),
        .home_i     (sweep_done),
        .cursor_o   (work_cursor),
        .row_o      (cur_row),
        .col_o      (cur_col)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_PLAY;
            work_board_q <= '0;
            board_q      <= '0;
            cursor_pos_q <= CURSOR_HOME;
            turn_q       <= 1'b0;
            move_count_q <= 7'd0;
            pass_cnt_q   <= 2'd0;
            place_err_q  <= 1'b0;
            game_over_q  <= 1'b0;
            cmd_ready_q  <= 1'b1;
            sweep_row_q  <= 4'd0;
            sweep_col_q  <= 4'd0;
        end else begin
            place_err_q <= 1'b0;

            // Shadow commit sees pre-command working state; frozen during a sweep.
            if (frame_start && (state_q != ST_CLEAR_SWEEP)) begin
                board_q      <= work_board_q;
                cursor_pos_q <= work_cursor;
            end

            case (state_q)
                ST_PLAY: begin
                    if (cmd_acc) begin
                        case (cmd_op)
                            CMD_PLACE: begin
                                if (cell_free) begin
                                    work_board_q[cur_row][cur_col] <= turn_q ? CELL_WHITE : CELL_BLACK;
                                    turn_q       <= ~turn_q;
                                    move_count_q <= move_count_q + 7'd1;
                                    pass_cnt_q   <= 2'd0;
                                end else begin
                                    place_err_q <= 1'b1;
                                end
                            end
                            CMD_PASS: begin
                                turn_q     <= ~turn_q;
                                pass_cnt_q <= pass_cnt_q + 2'd1;
                                if (pass_cnt_q == 2'd1) begin
                                    state_q     <= ST_OVER;
                                    game_over_q <= 1'b1;
                                end
                            end
                            CMD_CLEAR: begin
                                state_q     <= ST_CLEAR_SWEEP;
                                cmd_ready_q <= 1'b0;
                                sweep_row_q <= 4'd0;
                                sweep_col_q <= 4'd0;
                            end
                            default: ;
                        endcase
                    end
                end

                ST_OVER: begin
                    if (cmd_acc && (cmd_op == CMD_CLEAR)) begin
                        state_q     <= ST_CLEAR_SWEEP;
                        cmd_ready_q <= 1'b0;
                        game_over_q <= 1'b0;
                        sweep_row_q <= 4'd0;
                        sweep_col_q <= 4'd0;
                    end
                end

                ST_CLEAR_SWEEP: begin
                    if (sweep_done) begin
                        state_q      <= ST_PLAY;
                        cmd_ready_q  <= 1'b1;
                        turn_q       <= 1'b0;
                        move_count_q <= 7'd0;
                        pass_cnt_q   <= 2'd0;
                    end else begin
                        work_board_q[sweep_row_q][sweep_col_q] <= CELL_EMPTY;
                        if (sweep_col_q == 4'(BOARD_N - 1)) begin
                            sweep_col_q <= 4'd0;
                            sweep_row_q <= sweep_row_q + 4'd1;
                        end else begin
                            sweep_col_q <= sweep_col_q + 4'd1;
                        end
                    end
                end

                default: state_q <= ST_PLAY;
            endcase
        end
    end

    assign cmd_ready  = cmd_ready_q;
    assign board      = board_q;
    assign cursor_pos = cursor_pos_q;
    assign turn       = turn_q;
    assign move_count = move_count_q;
    assign place_err  = place_err_q;
    assign game_over  = game_over_q;

endmodule

// File: tb/tb_go_board_ctrl.sv
// Self-checking bench for go_board_ctrl: directed scenarios plus random
// command streams compared against a behavioural game model.
module tb_go_board_ctrl;

    localparam logic [2:0] C_NOP   = 3'd0;
    localparam logic [2:0] C_UP    = 3'd1;
    localparam logic [2:0] C_DOWN  = 3'd2;
    localparam logic [2:0] C_LEFT  = 3'd3;
    localparam logic [2:0] C_RIGHT = 3'd4;
    localparam logic [2:0] C_PLACE = 3'd5;
    localparam logic [2:0] C_PASS  = 3'd6;
    localparam logic [2:0] C_CLEAR = 3'd7;

    typedef logic [8:0][8:0][1:0] board_t;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       frame_start;
    logic       cmd_valid;
    logic [2:0] cmd;
    logic       cmd_ready;
    board_t     board;
    logic [7:0] cursor_pos;
    logic       turn;
    logic [6:0] move_count;
    logic       place_err;
    logic       game_over;

    go_board_ctrl #(
        .BOARD_N     (9),
        .CURSOR_HOME (8'h44)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .frame_start (frame_start),
        .cmd_valid   (cmd_valid),
        .cmd         (cmd),
        .cmd_ready   (cmd_ready),
        .board       (board),
        .cursor_pos  (cursor_pos),
        .turn        (turn),
        .move_count  (move_count),
        .place_err   (place_err),
        .game_over   (game_over)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Game model: working board/cursor, displayed copy, and a clear countdown.
    int mb[9][9];
    int sb[9][9];
    int mrow, mcol, srow, scol, mturn, mcount, mpass, mover, mbusy, mperr;

    function automatic void m_reset();
        for (int i = 0; i < 9; i++)
            for (int j = 0; j < 9; j++) begin
                mb[i][j] = 0;
                sb[i][j] = 0;
            end
        mrow = 4; mcol = 4; srow = 4; scol = 4;
        mturn = 0; mcount = 0; mpass = 0; mover = 0; mbusy = 0; mperr = 0;
    endfunction

    function automatic void m_finish_clear();
        for (int i = 0; i < 9; i++)
            for (int j = 0; j < 9; j++)
                mb[i][j] = 0;
        mrow = 4; mcol = 4; mturn = 0; mcount = 0; mpass = 0; mover = 0;
    endfunction

    function automatic void m_apply(input logic [2:0] c);
        if (mover != 0) begin
            if (c == C_CLEAR) begin
                mbusy = 82;
                mover = 0;
            end
        end else begin
            case (c)
                C_UP:    mrow = (mrow + 8) % 9;
                C_DOWN:  mrow = (mrow + 1) % 9;
                C_LEFT:  mcol = (mcol + 8) % 9;
                C_RIGHT: mcol = (mcol + 1) % 9;
                C_PLACE: begin
                    if (mb[mrow][mcol] == 0) begin
                        mb[mrow][mcol] = mturn + 1;
                        mturn  = 1 - mturn;
                        mcount = mcount + 1;
                        mpass  = 0;
                    end else begin
                        mperr = 1;
                    end
                end
                C_PASS: begin
                    mturn = 1 - mturn;
                    mpass = mpass + 1;
                    if (mpass == 2) mover = 1;
                end
                C_CLEAR: mbusy = 82;
                default: ;
            endcase
        end
    endfunction

    function automatic board_t exp_board();
        board_t e;
        for (int i = 0; i < 9; i++)
            for (int j = 0; j < 9; j++)
                e[i][j] = 2'(sb[i][j]);
        return e;
    endfunction

    function automatic logic [7:0] exp_cursor();
        return {4'(srow), 4'(scol)};
    endfunction

    // Drive one cycle, advance the model at the edge, settle just after it.
    task automatic cyc(input logic v, input logic [2:0] c, input logic fs);
        int pre;
        cmd_valid   = v;
        cmd         = c;
        frame_start = fs;
        @(posedge clk);
        pre   = mbusy;
        mperr = 0;
        if (fs && pre == 0) begin
            sb   = mb;
            srow = mrow;
            scol = mcol;
        end
        if (pre > 0) begin
            mbusy = mbusy - 1;
            if (mbusy == 0) m_finish_clear();
        end else if (v) begin
            m_apply(c);
        end
        #1;
        cmd_valid   = 1'b0;
        cmd         = C_NOP;
        frame_start = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; cmd_valid = 1'b0; cmd = C_NOP; frame_start = 1'b0;
        m_reset();
        #12;
        total++; if (board !== '0) begin bad++; $display("FAIL reset_board got=%h exp=0", board); end
        total++; if (cursor_pos !== 8'h44) begin bad++; $display("FAIL reset_cursor got=%h exp=44", cursor_pos); end
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", cmd_ready); end
        total++; if (turn !== 1'b0) begin bad++; $display("FAIL reset_turn got=%b exp=0", turn); end
        total++; if (move_count !== 7'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", move_count); end
        total++; if (place_err !== 1'b0 || game_over !== 1'b0) begin bad++; $display("FAIL reset_flags got=%b%b exp=00", place_err, game_over); end
        #1 reset_n = 1'b1;
        repeat (100) cyc(1'b1, C_NOP, 1'b0);
        total++; if (board !== '0) begin bad++; $display("FAIL nop_board got=%h exp=0", board); end
        total++; if (cursor_pos !== 8'h44) begin bad++; $display("FAIL nop_cursor got=%h exp=44", cursor_pos); end
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL nop_ready got=%b exp=1", cmd_ready); end
    endtask

    task automatic test_cursor();
        repeat (5) cyc(1'b1, C_UP, 1'b0);
        repeat (5) cyc(1'b1, C_LEFT, 1'b0);
        total++; if (cursor_pos !== 8'h44) begin bad++; $display("FAIL cur_uncommitted got=%h exp=44", cursor_pos); end
        cyc(1'b0, C_NOP, 1'b1);
        total++; if (cursor_pos !== 8'h88) begin bad++; $display("FAIL cur_wrap_ul got=%h exp=88", cursor_pos); end
        cyc(1'b1, C_RIGHT, 1'b0);
        cyc(1'b0, C_NOP, 1'b1);
        total++; if (cursor_pos !== 8'h80) begin bad++; $display("FAIL cur_wrap_r got=%h exp=80", cursor_pos); end
        total++; if (cursor_pos !== exp_cursor()) begin bad++; $display("FAIL cur_model got=%h exp=%h", cursor_pos, exp_cursor()); end
    endtask

    task automatic test_place();
        repeat (5) cyc(1'b1, C_DOWN, 1'b0);
        repeat (4) cyc(1'b1, C_RIGHT, 1'b0);
        cyc(1'b1, C_PLACE, 1'b0);
        total++; if (place_err !== 1'b0) begin bad++; $display("FAIL place1_err got=%b exp=0", place_err); end
        total++; if (turn !== 1'b1 || move_count !== 7'd1) begin bad++; $display("FAIL place1_state got=%b/%0d exp=1/1", turn, move_count); end
        cyc(1'b1, C_PLACE, 1'b0);
        total++; if (place_err !== 1'b1) begin bad++; $display("FAIL place2_err got=%b exp=1", place_err); end
        total++; if (turn !== 1'b1 || move_count !== 7'd1) begin bad++; $display("FAIL place2_state got=%b/%0d exp=1/1", turn, move_count); end
        cyc(1'b0, C_NOP, 1'b1);
        total++; if (place_err !== 1'b0) begin bad++; $display("FAIL place_err_pulse got=%b exp=0", place_err); end
        total++; if (board[4][4] !== 2'b01 || cursor_pos !== 8'h44) begin bad++; $display("FAIL place_show got=%b/%h exp=01/44", board[4][4], cursor_pos); end
        total++; if (board !== exp_board()) begin bad++; $display("FAIL place_board got=%h exp=%h", board, exp_board()); end
    endtask

    task automatic test_over_clear();
        cyc(1'b1, C_PASS, 1'b0);
        total++; if (game_over !== 1'b0) begin bad++; $display("FAIL pass1_over got=%b exp=0", game_over); end
        cyc(1'b1, C_PASS, 1'b0);
        total++; if (game_over !== 1'b1 || cmd_ready !== 1'b1) begin bad++; $display("FAIL pass2_over got=%b/%b exp=1/1", game_over, cmd_ready); end
        cyc(1'b1, C_PLACE, 1'b0);
        total++; if (move_count !== 7'd1 || turn !== 1'b1 || place_err !== 1'b0) begin bad++; $display("FAIL over_place got=%0d/%b/%b exp=1/1/0", move_count, turn, place_err); end
        cyc(1'b1, C_CLEAR, 1'b0);
        total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL clr_fall got=%b exp=0", cmd_ready); end
        for (int k = 1; k <= 82; k++) begin
            cyc(1'b1, C_PLACE, (k == 40));
            total++; if (cmd_ready !== (k == 82)) begin bad++; $display("FAIL clr_ready k=%0d got=%b exp=%b", k, cmd_ready, (k == 82)); end
            if (k == 40) begin
                total++; if (board[4][4] !== 2'b01) begin bad++; $display("FAIL clr_frozen got=%b exp=01", board[4][4]); end
            end
        end
        cyc(1'b0, C_NOP, 1'b1);
        total++; if (board !== '0 || cursor_pos !== 8'h44) begin bad++; $display("FAIL clr_show got=%h/%h exp=0/44", board, cursor_pos); end
        total++; if (game_over !== 1'b0 || move_count !== 7'd0 || turn !== 1'b0) begin bad++; $display("FAIL clr_state got=%b/%0d/%b exp=0/0/0", game_over, move_count, turn); end
    endtask

    task automatic test_same_edge();
        cyc(1'b1, C_PLACE, 1'b1);
        total++; if (board[4][4] !== 2'b00 || turn !== 1'b1) begin bad++; $display("FAIL same_edge got=%b/%b exp=00/1", board[4][4], turn); end
        cyc(1'b0, C_NOP, 1'b1);
        total++; if (board[4][4] !== 2'b01) begin bad++; $display("FAIL same_edge_next got=%b exp=01", board[4][4]); end
    endtask

    task automatic test_random();
        logic [2:0] c;
        logic       v;
        logic       fs;
        for (int n = 0; n < 3000; n++) begin
            v  = ($urandom_range(0, 3) != 0);
            c  = ($urandom_range(0, 99) < 2) ? C_CLEAR : 3'($urandom_range(0, 6));
            fs = ($urandom_range(0, 7) == 0);
            cyc(v, c, fs);
            total++; if (cmd_ready !== (mbusy == 0)) begin bad++; $display("FAIL rnd_ready n=%0d got=%b exp=%b", n, cmd_ready, (mbusy == 0)); end
            total++; if (board !== exp_board()) begin bad++; $display("FAIL rnd_board n=%0d got=%h exp=%h", n, board, exp_board()); end
            total++; if (cursor_pos !== exp_cursor()) begin bad++; $display("FAIL rnd_cursor n=%0d got=%h exp=%h", n, cursor_pos, exp_cursor()); end
            total++; if (turn !== 1'(mturn) || move_count !== 7'(mcount)) begin bad++; $display("FAIL rnd_turn_count n=%0d got=%b/%0d exp=%0d/%0d", n, turn, move_count, mturn, mcount); end
            total++; if (place_err !== 1'(mperr) || game_over !== 1'(mover)) begin bad++; $display("FAIL rnd_flags n=%0d got=%b/%b exp=%0d/%0d", n, place_err, game_over, mperr, mover); end
        end
    endtask

    task automatic test_reset_mid_sweep();
        #2 reset_n = 1'b0;
        m_reset();
        #2 reset_n = 1'b1;
        cyc(1'b1, C_PLACE, 1'b0);
        cyc(1'b0, C_NOP, 1'b1);
        total++; if (board[4][4] !== 2'b01) begin bad++; $display("FAIL rst_pre_stone got=%b exp=01", board[4][4]); end
        cyc(1'b1, C_CLEAR, 1'b0);
        repeat (20) cyc(1'b0, C_NOP, 1'b0);
        total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL rst_in_sweep got=%b exp=0", cmd_ready); end
        #2 reset_n = 1'b0;
        m_reset();
        #1;
        total++; if (board !== '0 || cursor_pos !== 8'h44) begin bad++; $display("FAIL rst_async_out got=%h/%h exp=0/44", board, cursor_pos); end
        total++; if (cmd_ready !== 1'b1 || turn !== 1'b0 || move_count !== 7'd0 || game_over !== 1'b0) begin bad++; $display("FAIL rst_async_state got=%b/%b/%0d/%b exp=1/0/0/0", cmd_ready, turn, move_count, game_over); end
        #2 reset_n = 1'b1;
        cyc(1'b1, C_RIGHT, 1'b0);
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL rst_play_ready got=%b exp=1", cmd_ready); end
        cyc(1'b0, C_NOP, 1'b1);
        total++; if (cursor_pos !== 8'h45) begin bad++; $display("FAIL rst_play_move got=%h exp=45", cursor_pos); end
    endtask

    initial begin
        test_reset();
        test_cursor();
        test_place();
        test_over_clear();
        test_same_edge();
        test_random();
        test_reset_mid_sweep();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
